sfence_vma_ctrl: RTL and testbench

Sequencer for `SFENCE.VMA` in the execute stage. It captures the virtual address and ASID operands when the fence issues alongside a CSR-buffer operation, and holds them until the scoreboard commits the instruction. It then waits for the store path to drain and issues a single-cycle TLB flush request, carrying the captured operands, to the LSU's ITLB/DTLB. This replaces the ad-hoc operand latching in the execute stage with an explicit, flush-aware state machine.

---
 rtl/sfence_vma_ctrl.sv | 101 ++++++++++
 tb/tb_sfence_vma_ctrl.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/sfence_vma_ctrl.sv
// sfence_vma_ctrl: captures SFENCE.VMA operands, waits for commit and store drain, then issues one TLB flush pulse.
module sfence_vma_ctrl #(
    parameter int ASID_WIDTH    = 1,
    parameter int VLEN          = 39,
    parameter int TRANS_ID_BITS = 3
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     flush_i,
    input  logic                     sfence_valid_i,
    input  logic [TRANS_ID_BITS-1:0] trans_id_i,
    input  logic [VLEN-1:0]          rs1_i,
    input  logic [ASID_WIDTH-1:0]    rs2_i,
    input  logic                     rs1_is_x0_i,
    input  logic                     rs2_is_x0_i,
    output logic                     sfence_ready_o,
    input  logic                     commit_i,
    input  logic [TRANS_ID_BITS-1:0] commit_trans_id_i,
    input  logic                     no_st_pending_i,
    input  logic                     wbuffer_empty_i,
    output logic                     tlb_flush_o,
    output logic [VLEN-1:0]          vaddr_o,
    output logic [ASID_WIDTH-1:0]    asid_o,
    output logic                     all_vaddr_o,
    output logic                     all_asid_o,
    output logic                     done_o,
    output logic                     busy_o,
    output logic [7:0]               drain_cycles_o
);
    localparam logic [2:0] IDLE        = 3'd0;
    localparam logic [2:0] WAIT_COMMIT = 3'd1;
    localparam logic [2:0] DRAIN       = 3'd2;
    localparam logic [2:0] FLUSH       = 3'd3;
    localparam logic [2:0] DONE        = 3'd4;

    logic [2:0]               r_state;
    logic [VLEN-1:0]          r_vaddr;
    logic [ASID_WIDTH-1:0]    r_asid;
    logic [TRANS_ID_BITS-1:0] r_trans_id;
    logic                     r_all_vaddr;
    logic                     r_all_asid;
    logic [7:0]               r_drain_cnt;
    logic [7:0]               r_drain_cycles;
    logic                     w_commit_hit;
    logic                     w_drained;

    assign w_commit_hit = commit_i && (commit_trans_id_i == r_trans_id);
    assign w_drained    = no_st_pending_i && wbuffer_empty_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state        <= IDLE;
            r_vaddr        <= '0;
            r_asid         <= '0;
            r_trans_id     <= '0;
            r_all_vaddr    <= 1'b0;
            r_all_asid     <= 1'b0;
            r_drain_cnt    <= '0;
            r_drain_cycles <= '0;
        end else begin
            case (r_state)
                IDLE: if (sfence_valid_i && !flush_i) begin
                    r_vaddr     <= rs1_i;
                    r_asid      <= rs2_i;
                    r_trans_id  <= trans_id_i;
                    r_all_vaddr <= rs1_is_x0_i;
                    r_all_asid  <= rs2_is_x0_i;
                    r_state     <= WAIT_COMMIT;
                end
                WAIT_COMMIT: if (flush_i) begin
                    r_state <= IDLE;
                end else if (w_commit_hit) begin
                    r_drain_cnt <= '0;
                    r_state     <= DRAIN;
                end
                // committed: a pipeline flush can no longer abort the fence
                DRAIN: if (w_drained) begin
                    r_state <= FLUSH;
                end else if (r_drain_cnt != 8'hff) begin
                    r_drain_cnt <= r_drain_cnt + 8'd1;
                end
                FLUSH: r_state <= DONE;
                DONE: begin
                    r_drain_cycles <= r_drain_cnt;
                    r_state        <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign sfence_ready_o = (r_state == IDLE);
    assign busy_o         = (r_state != IDLE);
    assign tlb_flush_o    = (r_state == FLUSH);
    assign done_o         = (r_state == DONE);
    assign vaddr_o        = tlb_flush_o ? r_vaddr : '0;
    assign asid_o         = tlb_flush_o ? r_asid : '0;
    assign all_vaddr_o    = tlb_flush_o && r_all_vaddr;
    assign all_asid_o     = tlb_flush_o && r_all_asid;
    assign drain_cycles_o = r_drain_cycles;
endmodule

// File: tb/tb_sfence_vma_ctrl.sv
// tb_sfence_vma_ctrl: directed and random checks of sfence_vma_ctrl against a transaction-level model.
module tb_sfence_vma_ctrl;
    logic        clk = 1'b0;
    logic        rst, flush, valid, rs1_x0, rs2_x0, commit, nsp, wbe;
    logic [2:0]  tid, cid;
    logic [38:0] rs1;
    logic [0:0]  rs2;
    logic        ready, tlb, allv, alla, done, busy;
    logic [38:0] vaddr;
    logic [0:0]  asid;
    logic [7:0]  dcyc;

    int checks = 0;
    int failures = 0;

    // model: which part of the fence lifetime is in progress, plus its operands
    logic        m_held = 0, m_drain = 0, m_fl = 0, m_dn = 0;
    logic [38:0] m_va = '0;
    logic [0:0]  m_as = '0;
    logic        m_av = 0, m_aa = 0;
    logic [2:0]  m_id = '0;
    int          m_cnt = 0, m_dc = 0;

    always #5 clk = ~clk;

    sfence_vma_ctrl dut (
        .clk_i(clk), .rst_i(rst), .flush_i(flush), .sfence_valid_i(valid),
        .trans_id_i(tid), .rs1_i(rs1), .rs2_i(rs2), .rs1_is_x0_i(rs1_x0),
        .rs2_is_x0_i(rs2_x0), .sfence_ready_o(ready), .commit_i(commit),
        .commit_trans_id_i(cid), .no_st_pending_i(nsp), .wbuffer_empty_i(wbe),
        .tlb_flush_o(tlb), .vaddr_o(vaddr), .asid_o(asid), .all_vaddr_o(allv),
        .all_asid_o(alla), .done_o(done), .busy_o(busy), .drain_cycles_o(dcyc)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_step();
        if (rst) begin
            m_held = 0; m_drain = 0; m_fl = 0; m_dn = 0; m_dc = 0; m_cnt = 0;
        end else if (m_held) begin
            if (flush) m_held = 0;
            else if (commit && cid == m_id) begin
                m_held = 0; m_drain = 1; m_cnt = 0;
            end
        end else if (m_drain) begin
            if (nsp && wbe) begin
                m_drain = 0; m_fl = 1;
            end else if (m_cnt < 255) m_cnt++;
        end else if (m_fl) begin
            m_fl = 0; m_dn = 1;
        end else if (m_dn) begin
            m_dn = 0; m_dc = m_cnt;
        end else if (valid && !flush) begin
            m_held = 1; m_va = rs1; m_as = rs2; m_av = rs1_x0; m_aa = rs2_x0; m_id = tid;
        end
    endtask

    task automatic tick();
        logic idle;
        model_step();
        @(posedge clk);
        #1;
        idle = !(m_held || m_drain || m_fl || m_dn);
        check("ready", ready, idle);
        check("busy", busy, !idle);
        check("tlb_flush", tlb, m_fl);
        check("vaddr", vaddr, m_fl ? m_va : 39'd0);
        check("asid", asid, m_fl ? m_as : 1'b0);
        check("all_vaddr", allv, m_fl && m_av);
        check("all_asid", alla, m_fl && m_aa);
        check("done", done, m_dn);
        check("drain_cycles", dcyc, m_dc);
    endtask

    task automatic quiet();
        rst = 0; flush = 0; valid = 0; commit = 0; nsp = 1; wbe = 1;
    endtask

    task automatic issue(input logic [38:0] a, input logic [0:0] s, input logic [2:0] id,
                         input logic x1, input logic x2);
        valid = 1; rs1 = a; rs2 = s; tid = id; rs1_x0 = x1; rs2_x0 = x2;
        tick();
        valid = 0;
    endtask

    initial begin
        quiet();
        rst = 1; tid = 0; cid = 0; rs1 = 0; rs2 = 0; rs1_x0 = 0; rs2_x0 = 0;
        tick();
        check("reset_ready", ready, 1'b1);
        check("reset_busy", busy, 1'b0);
        rst = 0;

        // basic fence
        issue(39'h12345, 1'b1, 3'd3, 0, 0);
        tick();
        commit = 1; cid = 3; tick(); commit = 0;
        tick();
        check("basic_tlb", tlb, 1'b1);
        check("basic_vaddr", vaddr, 39'h12345);
        check("basic_asid", asid, 1'b1);
        tick();
        check("basic_done", done, 1'b1);
        check("basic_tlb_off", tlb, 1'b0);
        tick();
        check("basic_drain", dcyc, 8'd0);
        check("basic_ready", ready, 1'b1);

        // x0 operands
        issue(39'h7777, 1'b0, 3'd5, 1, 1);
        commit = 1; cid = 5; tick(); commit = 0;
        tick();
        check("x0_all_vaddr", allv, 1'b1);
        check("x0_all_asid", alla, 1'b1);
        tick(); tick();

        // squash: flush beats a matching commit
        issue(39'h4321, 1'b1, 3'd2, 0, 0);
        flush = 1; commit = 1; cid = 2; tick(); flush = 0; commit = 0;
        check("squash_ready", ready, 1'b1);
        repeat (4) begin
            tick();
            check("squash_no_tlb", tlb, 1'b0);
            check("squash_no_done", done, 1'b0);
        end

        // drain stall with a flush pulse that must not abort
        issue(39'h2468, 1'b0, 3'd6, 0, 0);
        commit = 1; cid = 6; tick(); commit = 0;
        nsp = 0;
        for (int i = 0; i < 7; i++) begin
            flush = (i == 3);
            tick();
        end
        flush = 0; nsp = 1;
        tick();
        check("stall_tlb", tlb, 1'b1);
        check("stall_vaddr", vaddr, 39'h2468);
        tick(); tick();
        check("stall_drain", dcyc, 8'd7);

        // back-pressure and wrong-ID commit
        issue(39'h5555, 1'b0, 3'd1, 0, 0);
        valid = 1; rs1 = 39'hAAAA; commit = 1; cid = 4; tick();
        check("bp_ready", ready, 1'b0);
        check("bp_busy", busy, 1'b1);
        valid = 0; commit = 1; cid = 1; tick(); commit = 0;
        tick();
        check("bp_vaddr", vaddr, 39'h5555);
        tick(); tick();

        // drain counter saturation
        issue(39'h1, 1'b0, 3'd0, 0, 0);
        commit = 1; cid = 0; tick(); commit = 0;
        wbe = 0;
        repeat (300) tick();
        wbe = 1;
        tick(); tick(); tick();
        check("sat_drain", dcyc, 8'd255);

        // reset mid-DRAIN
        issue(39'h9999, 1'b1, 3'd7, 0, 0);
        commit = 1; cid = 7; tick(); commit = 0;
        nsp = 0; tick(); tick();
        rst = 1; tick(); rst = 0; nsp = 1;
        check("rst_ready", ready, 1'b1);
        check("rst_drain", dcyc, 8'd0);
        repeat (3) begin
            tick();
            check("rst_no_tlb", tlb, 1'b0);
        end

        // random traffic
        for (int i = 0; i < 2000; i++) begin
            rst    = ($urandom_range(0, 99) == 0);
            flush  = ($urandom_range(0, 7) == 0);
            valid  = ($urandom_range(0, 2) == 0);
            commit = ($urandom_range(0, 2) == 0);
            cid    = $urandom_range(0, 1) ? m_id : 3'($urandom);
            tid    = 3'($urandom);
            rs1    = 39'({$urandom(), $urandom()});
            rs2    = 1'($urandom);
            rs1_x0 = 1'($urandom);
            rs2_x0 = 1'($urandom);
            nsp    = ($urandom_range(0, 3) != 0);
            wbe    = ($urandom_range(0, 3) != 0);
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
